// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed driver for a 4-digit common-anode FND.
// It steps a digit select through slots 0..3 and decodes the muxed digit to
// active-low segments. Each slot opens with a blanking interval, which hides
// the one-cycle lag of the registered segment byte behind dark anodes.
module fnd_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] digit_in,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int                CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        OFF,
        BLANK,
        DRIVE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [6:0]       seg_code;

    // Seven-segment decode of the muxed digit, {g,f,e,d,c,b,a}, active-low.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        seg_code = 7'h7F;
        case (digit_in)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            4'hF: seg_code = 7'h0E;
            default: seg_code = 7'h7F;
        endcase
    end

    // Anode strobe follows state and registered sel directly, so a change in
    // blank_mask takes effect in the same cycle.
    always_comb begin
        an = 4'hF;
        if (state == DRIVE && !blank_mask[sel]) begin
            an = ~(4'b0001 << sel);
        end
    end

    // Scan FSM, slot counter and registered segment byte.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: only control state and the outputs that must be dark out of
        // reset are reset here; the block holds no memory array.
        if (!reset_n) begin
            state   <= OFF;
            div_cnt <= '0;
            sel     <= 2'd0;
            seg     <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, whatever the statement order.
            seg <= en ? {~dp_in[sel], seg_code} : 8'hFF;

            if (!en) begin
                // Disable wins over everything, including a slot end.
                state   <= OFF;
                div_cnt <= '0;
                sel     <= 2'd0;
            end else begin
                case (state)
                    OFF: begin
                        state   <= BLANK;
                        div_cnt <= '0;
                        sel     <= 2'd0;
                    end
                    BLANK: begin
                        div_cnt <= div_cnt + CNT_ONE;
                        if (div_cnt == BLANK_LAST) begin
                            state <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (div_cnt == SLOT_LAST) begin
                            div_cnt <= '0;
                            sel     <= sel + 2'd1;
                            state   <= BLANK;
                        end else begin
                            div_cnt <= div_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state   <= OFF;
                        div_cnt <= '0;
                        sel     <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver with an 8-cycle slot and 2 blank cycles. A mux
// model feeds digit_in from sel. Stimulus pushes the expected outputs for every
// cycle into a queue, and a monitor pops and compares them on the falling edge.
module tb_fnd_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] digit_in;
    logic [3:0] dp_in;
    logic [3:0] blank_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic [7:0] seg;

    logic [3:0] digits [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic       force_dig;
    logic [3:0] fdig;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Model state: m_on = scanning; m_cnt = cycle position within the refresh.
    bit         m_on;
    int         m_cnt;
    logic [7:0] m_seg;
    bit         ghost_en;
    int         guard;

    fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .digit_in   (digit_in),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .sel        (sel),
        .an         (an),
        .seg        (seg)
    );

    always #5 if (clk_run) clk = ~clk;

    // Mux model of the FND controller.
    assign digit_in = force_dig ? fdig : digits[sel];

    function automatic logic [6:0] seg_dec(logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance one clock and push the model's expected outputs for the new cycle.
    // Inputs change only at negedge+1, so they are stable across the edge.
    task automatic tick();
        logic [1:0] s_old;
        logic [3:0] d;
        exp_t       e;
        int         o;
        s_old = m_on ? 2'(m_cnt / SD) : 2'd0;
        d     = force_dig ? fdig : digits[s_old];
        @(posedge clk);
        #1;
        m_seg = en ? {~dp_in[s_old], seg_dec(d)} : 8'hFF;
        if (!en) begin
            m_on  = 1'b0;
            m_cnt = 0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + 1) % (4 * SD);
        end
        e.sel = m_on ? 2'(m_cnt / SD) : 2'd0;
        o     = m_cnt % SD;
        e.an  = (!m_on || o < BC || blank_mask[e.sel]) ? 4'hF : ~(4'b0001 << e.sel);
        e.seg = m_seg;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("sel", 32'(sel), 32'(mon_e.sel));
                check("an", 32'(an), 32'(mon_e.an));
                check("seg", 32'(seg), 32'(mon_e.seg));
                if (ghost_en && mon_e.an != 4'hF) begin
                    check("ghost", 32'(seg[6:0]), 32'(seg_dec(digits[mon_e.sel])));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset_n    = 1'b1;
        en         = 1'b0;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        force_dig  = 1'b0;
        fdig       = 4'h0;
        ghost_en   = 1'b1;
        m_on       = 1'b0;
        m_cnt      = 0;
        m_seg      = 8'hFF;

        // Asynchronous reset with the clock stopped.
        #5 reset_n = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);

        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // Idle while disabled.
        repeat (2) tick();

        // Scan order: digits {1,2,3,4}, slightly more than one full refresh.
        en = 1'b1;
        repeat (5 * SD) tick();

        // Decode sweep: force 0..F while in slot 0, dp lit on slot 0 only.
        ghost_en = 1'b0;
        dp_in    = 4'b0001;
        for (int v = 0; v < 16;) begin
            if (m_on && m_cnt < SD) begin
                force_dig = 1'b1;
                fdig      = 4'(v);
                v++;
            end else begin
                force_dig = 1'b0;
            end
            tick();
        end
        force_dig = 1'b0;
        ghost_en  = 1'b1;
        dp_in     = 4'h0;
        repeat (SD) tick();

        // Blank mask on digit 3 for a full refresh.
        blank_mask = 4'b1000;
        repeat (4 * SD) tick();
        blank_mask = 4'h0;

        // Enable abort in DRIVE of slot 2, then re-enable.
        guard = 0;
        while (!(m_cnt >= 2 * SD + BC && m_cnt < 3 * SD) && guard < 100) begin
            tick();
            guard++;
        end
        check("reach_slot2", 32'(guard < 100), 32'h1);
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (SD + 4) tick();

        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
